// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Optional hit/miss counters: define DCACHE_STATS_EN.
`timescale 1ns/1ps
module dcache_controller #(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256,
  parameter int TAG_BITS  = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state;

  logic [LINE_BITS-1:0] data_arr [NUM_SETS];
  logic [TAG_BITS-1:0]  tag_arr  [NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;

  logic [TAG_BITS-1:0]  tag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    wsel;
  logic                 req;
  logic                 store;
  logic                 hit;
  logic                 miss;
  logic                 wr_hit;
  logic                 refill_ack;
  logic                 unused_addr_bits;

  assign tag   = cpu_addr_i[31 -: TAG_BITS];
  assign idx   = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel  = cpu_addr_i[2 +: WSEL_W];
  assign req   = cpu_MemRead_i | cpu_MemWrite_i;
  assign store = cpu_MemWrite_i;
  assign hit   = valid_q[idx] & (tag_arr[idx] == tag);

  assign miss       = (state == IDLE) & req & ~hit;
  assign wr_hit     = (state == IDLE) & store & hit;
  assign refill_ack = (state == REFILL) & mem_ack_i;

  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign cpu_stall_o = (state != IDLE) | (req & ~hit);
  assign cpu_data_o  = data_arr[idx][{wsel, 5'b0} +: 32];

  // Miss sequencing: optional write-back of the victim, then refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            mem_enable_o <= 1'b1;
            if (dirty_q[idx]) begin
              state       <= WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_arr[idx], idx, {OFF_W{1'b0}}};
              mem_data_o  <= data_arr[idx];
            end else begin
              state       <= REFILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line status bits: refill validates and cleans, store hit dirties.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_ack) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage; not cleared, only gated off during reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill_ack) begin
        data_arr[idx] <= mem_data_i;
        tag_arr[idx]  <= tag;
      end else if (wr_hit) begin
        data_arr[idx][{wsel, 5'b0} +: 32] <= cpu_data_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill_done_q;

  // Access statistics; the hit that completes a refill is not a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_done_q <= 1'b0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
    end else begin
      refill_done_q <= refill_ack;
      if ((state == IDLE) & req & hit & ~refill_done_q)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a line-level cache/memory model.
// Checks outputs every cycle against the model, plus literal pins.
`timescale 1ns/1ps
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_rd;
  logic         cpu_wr;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // model: cache contents per set, and backing memory per line address
  logic         m_valid [16];
  logic         m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_data  [16];
  logic [255:0] mem_store [logic [31:0]];
  int           n_hit = 0;
  int           n_miss = 0;

  // expectations for the compare process
  logic         chk = 1'b0;
  logic         exp_stall, exp_en, exp_wr, exp_rd;
  logic [31:0]  exp_addr, exp_rdata;
  logic [255:0] exp_wdata;

  // DUT observations for literal pins
  logic [31:0]  last_wb_addr, last_rf_addr, last_rdata;
  logic [255:0] last_wb_data;
  logic         last_first_wr;

  task automatic check(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk) begin
      check("stall", 256'(cpu_stall_o), 256'(exp_stall));
      check("mem_en", 256'(mem_enable_o), 256'(exp_en));
      check("mem_wr", 256'(mem_write_o), 256'(exp_wr));
      if (exp_en)
        check("mem_addr", 256'(mem_addr_o), 256'(exp_addr));
      if (exp_en && exp_wr)
        check("mem_wdata", mem_data_o, exp_wdata);
      if (exp_rd)
        check("rdata", 256'(cpu_data_o), 256'(exp_rdata));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = la ^ {8'(k + 1), 24'h0A5A5A};
    return l;
  endfunction

  task automatic access(input logic [31:0] a, input logic rd,
                        input logic wr, input logic [31:0] d,
                        input int wbd, input int rfd);
    logic [3:0]  idx;
    logic [22:0] tg;
    int          w;
    logic [31:0] la;
    logic [31:0] ol;
    idx = a[8:5];
    tg  = a[31:9];
    w   = int'(a[4:2]);
    la  = {a[31:5], 5'b0};
    cpu_addr  = a;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_wdata = d;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      n_miss++;
      exp_stall = 1'b1;
      exp_en    = 1'b0;
      exp_wr    = 1'b0;
      exp_rd    = 1'b0;
      chk       = 1'b1;
      step();
      last_first_wr = mem_write_o;
      if (m_dirty[idx]) begin
        ol = {m_tag[idx], idx, 5'b0};
        for (int i = 0; i <= wbd; i++) begin
          exp_en    = 1'b1;
          exp_wr    = 1'b1;
          exp_addr  = ol;
          exp_wdata = m_data[idx];
          mem_ack   = (i == wbd);
          if (i == 0) begin
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_data_o;
          end
          step();
        end
        mem_ack = 1'b0;
        mem_store[ol] = m_data[idx];
      end
      for (int i = 0; i <= rfd; i++) begin
        exp_en    = 1'b1;
        exp_wr    = 1'b0;
        exp_addr  = la;
        mem_ack   = (i == rfd);
        mem_rdata = (i == rfd) ? mem_line(la) : '0;
        if (i == 0) last_rf_addr = mem_addr_o;
        step();
      end
      mem_ack    = 1'b0;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = mem_line(la);
    end else begin
      n_hit++;
    end
    exp_stall = 1'b0;
    exp_en    = 1'b0;
    exp_wr    = 1'b0;
    exp_rd    = !wr;
    exp_rdata = m_data[idx][w*32 +: 32];
    chk       = 1'b1;
    #1;
    last_rdata = cpu_data_o;
    step();
    if (wr) begin
      m_data[idx][w*32 +: 32] = d;
      m_dirty[idx] = 1'b1;
    end
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    exp_rd = 1'b0;
  endtask

  task automatic idle();
    exp_stall = 1'b0;
    exp_en    = 1'b0;
    exp_wr    = 1'b0;
    exp_rd    = 1'b0;
    chk       = 1'b1;
    step();
  endtask

  initial begin
    logic [255:0] pre;
    rst_i     = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int s = 0; s < 16; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = '0;
      m_data[s]  = '0;
    end
    pre = mem_line(32'h40);
    pre[95:64] = 32'hDEAD_BEEF;
    mem_store[32'h40] = pre;

    repeat (2) step();
    rst_i = 1'b0;
    idle();
    check("pin_rst_addr", 256'(mem_addr_o), 256'h0);
    check("pin_rst_wr", 256'(mem_write_o), 256'h0);

    // cold miss, then hit on word2 of the refilled line
    access(32'h40, 1'b1, 1'b0, 32'h0, 0, 2);
    check("pin_cold_rf_addr", 256'(last_rf_addr), 256'h40);
    access(32'h48, 1'b1, 1'b0, 32'h0, 0, 0);
    check("pin_ld_48", 256'(last_rdata), 256'hDEAD_BEEF);

    // store hit then read back
    access(32'h44, 1'b0, 1'b1, 32'h1234_5678, 0, 0);
    access(32'h44, 1'b1, 1'b0, 32'h0, 0, 0);
    check("pin_ld_44", 256'(last_rdata), 256'h1234_5678);

    // dirty conflict miss
    access(32'h240, 1'b1, 1'b0, 32'h0, 1, 0);
    check("pin_wb_first", 256'(last_first_wr), 256'h1);
    check("pin_wb_addr", 256'(last_wb_addr), 256'h40);
    check("pin_wb_word1", 256'(last_wb_data[63:32]), 256'h1234_5678);
    check("pin_rf_addr", 256'(last_rf_addr), 256'h240);

    // clean conflict miss skips write-back; written-back data returns
    access(32'h44, 1'b1, 1'b0, 32'h0, 0, 0);
    check("pin_clean_no_wb", 256'(last_first_wr), 256'h0);
    check("pin_ld_44_again", 256'(last_rdata), 256'h1234_5678);

    // slow memory: ten-cycle refill wait
    access(32'h84, 1'b1, 1'b0, 32'h0, 0, 10);
    idle();

    // read+write together is a store; write-allocate on miss
    access(32'h1008, 1'b1, 1'b1, 32'hCAFE_F00D, 0, 1);
    access(32'h1008, 1'b1, 1'b0, 32'h0, 0, 0);
    check("pin_ld_1008", 256'(last_rdata), 256'hCAFE_F00D);
    access(32'h3004, 1'b1, 1'b0, 32'h0, 3, 2);
    access(32'h1008, 1'b1, 1'b0, 32'h0, 2, 0);
    check("pin_ld_1008_wb", 256'(last_rdata), 256'hCAFE_F00D);
    idle();

    // reset in the middle of a refill
    cpu_addr = 32'h300;
    cpu_rd   = 1'b1;
    exp_stall = 1'b1;
    exp_en    = 1'b0;
    exp_wr    = 1'b0;
    exp_rd    = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      exp_en   = 1'b1;
      exp_addr = 32'h300;
      step();
    end
    rst_i  = 1'b1;
    cpu_rd = 1'b0;
    chk    = 1'b0;
    step();
    rst_i = 1'b0;
    for (int s = 0; s < 16; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    n_hit  = 0;
    n_miss = 0;
    check("pin_rst_en_drop", 256'(mem_enable_o), 256'h0);
    mem_ack   = 1'b1;
    mem_rdata = {8{32'hBAD0_BAD0}};
    idle();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    idle();
    access(32'h300, 1'b1, 1'b0, 32'h0, 0, 1);
    check("pin_reissue_miss", 256'(last_rf_addr), 256'h300);
    access(32'h48, 1'b1, 1'b0, 32'h0, 0, 0);
    check("pin_ld_48_post_rst", 256'(last_rdata), 256'hDEAD_BEEF);
    idle();

`ifdef DCACHE_STATS_EN
    check("hit_cnt", 256'(hit_cnt_o), 256'(n_hit));
    check("miss_cnt", 256'(miss_cnt_o), 256'(n_miss));
    check("pin_miss_cnt", 256'(miss_cnt_o), 256'h2);
`endif

    chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
